// File: rtl/id_exe_reg.sv
// id_exe_reg: decode -> execute pipeline register for the 5-stage RV32I core.
// Captures instruction, PC, operands and write-back control once per cycle,
// inserts bubbles on flush or a decode-only stall, and holds on an execute
// stall. It also returns the load flag and the destination register to decode
// so decode can detect load-use hazards.
// Optional feature: define ID_EXE_PERF_CNT_EN to add the saturating counters
// bubble_cnt_out and flush_cnt_out.
module id_exe_reg #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    RDATA_WIDTH = 32,
    parameter int                    RADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] NOP_INST    = 32'h00000013
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic [DATA_WIDTH-1:0]  inst_in,
    input  logic [ADDR_WIDTH-1:0]  inst_addr_in,
    input  logic [RDATA_WIDTH-1:0] op1_in,
    input  logic [RDATA_WIDTH-1:0] op2_in,
    input  logic                   reg_we_in,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
    input  logic                   stall_id_in,
    input  logic                   stall_exe_in,
    input  logic                   flush_in,
    output logic [DATA_WIDTH-1:0]  inst_out,
    output logic [ADDR_WIDTH-1:0]  inst_addr_out,
    output logic [RDATA_WIDTH-1:0] op1_out,
    output logic [RDATA_WIDTH-1:0] op2_out,
    output logic                   reg_we_out,
    output logic [RADDR_WIDTH-1:0] reg_waddr_out,
    output logic                   valid_out,
    output logic [RADDR_WIDTH-1:0] exe_rd_out,
    output logic                   pre_inst_is_load_out
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [31:0]            bubble_cnt_out,
    output logic [31:0]            flush_cnt_out
`endif
);

    // RV32I base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]             w_opcode;
    logic                   w_opcode_valid;
    logic                   w_is_load;
    logic                   w_bubble;
    logic                   w_capture;

    logic [DATA_WIDTH-1:0]  r_inst;
    logic [ADDR_WIDTH-1:0]  r_inst_addr;
    logic [RDATA_WIDTH-1:0] r_op1;
    logic [RDATA_WIDTH-1:0] r_op2;
    logic                   r_reg_we;
    logic [RADDR_WIDTH-1:0] r_reg_waddr;
    logic                   r_valid;
    logic                   r_is_load;

    assign w_opcode = inst_in[6:0];

    // Classify the incoming opcode against the RV32I base set
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        w_opcode_valid = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: w_opcode_valid = 1'b1;
            default:                                 w_opcode_valid = 1'b0;
        endcase
    end

    // A load only creates a hazard if it actually writes a register
    assign w_is_load = (w_opcode == OPC_LOAD) && reg_we_in;

    // Flush beats everything; a decode-only stall must not let the held
    // instruction issue twice, so it also becomes a bubble
    assign w_bubble  = flush_in || (stall_id_in && !stall_exe_in);
    assign w_capture = !flush_in && !stall_id_in && !stall_exe_in;

    // Pipeline register: bubble, capture, or hold (execute stall)
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            r_inst      <= NOP_INST;
            r_inst_addr <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_valid     <= 1'b0;
            r_is_load   <= 1'b0;
        end else if (w_bubble) begin
            r_inst      <= NOP_INST;
            r_inst_addr <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_valid     <= 1'b0;
            r_is_load   <= 1'b0;
        end else if (w_capture) begin
            r_inst      <= inst_in;
            r_inst_addr <= inst_addr_in;
            r_op1       <= op1_in;
            r_op2       <= op2_in;
            r_reg_we    <= reg_we_in;
            r_reg_waddr <= reg_waddr_in;
            r_valid     <= w_opcode_valid;
            r_is_load   <= w_is_load;
        end
    end

    assign inst_out             = r_inst;
    assign inst_addr_out        = r_inst_addr;
    assign op1_out              = r_op1;
    assign op2_out              = r_op2;
    assign reg_we_out           = r_reg_we;
    assign reg_waddr_out        = r_reg_waddr;
    assign valid_out            = r_valid;
    assign pre_inst_is_load_out = r_is_load;
    // Hide rd when nothing is written back so decode never matches a stale rd
    assign exe_rd_out           = r_reg_we ? r_reg_waddr : '0;

`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_bubble;

    // A flush cycle counts only as a flush, even with stall_id_in high
    assign w_stall_bubble = !flush_in && stall_id_in && !stall_exe_in;

    // Saturating event counters for bubbles and flushes
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_stall_bubble && (r_bubble_cnt != 32'hFFFFFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush_in && (r_flush_cnt != 32'hFFFFFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt_out = r_bubble_cnt;
    assign flush_cnt_out  = r_flush_cnt;
`endif

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage RV32I core.
- Captures the decoded instruction, PC, forwarded operands and write-back control each cycle.
- Honours stall and flush requests from ctrl.
- Feeds the "previous instruction is a load" and destination-register information back to decode, which uses them for load-use hazard detection.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, instruction address width
- RDATA_WIDTH, 32, register data width
- RADDR_WIDTH, 5, register address width
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk_in  input  1  core clock; all state updates on rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- inst_in  input  DATA_WIDTH  decoded instruction from decode
- inst_addr_in  input  ADDR_WIDTH  instruction PC from decode
- op1_in  input  RDATA_WIDTH  forwarded operand 1
- op2_in  input  RDATA_WIDTH  forwarded operand 2
- reg_we_in  input  1  write-back enable
- reg_waddr_in  input  RADDR_WIDTH  write-back register
- stall_id_in  input  1  ctrl: decode stage held
- stall_exe_in  input  1  ctrl: execute stage held
- flush_in  input  1  ctrl: taken jump/branch, kill the younger instruction
- inst_out  output  DATA_WIDTH  instruction to execute
- inst_addr_out  output  ADDR_WIDTH  PC to execute
- op1_out  output  RDATA_WIDTH  operand 1 to execute
- op2_out  output  RDATA_WIDTH  operand 2 to execute
- reg_we_out  output  1  write-back enable to execute
- reg_waddr_out  output  RADDR_WIDTH  write-back register to execute
- valid_out  output  1  register holds a real (non-bubble) instruction
- exe_rd_out  output  RADDR_WIDTH  to decode: rd of the instruction in execute
- pre_inst_is_load_out  output  1  to decode: instruction in execute is a load

Behaviour:
- Reset (reset_n_in low, asynchronous, any time including mid-stall):
  - inst_out=NOP_INST
  - inst_addr_out, op1_out, op2_out, reg_waddr_out = 0
  - reg_we_out=0, valid_out=0, pre_inst_is_load_out=0, exe_rd_out=0
- Reset release: register takes normal updates from the first rising edge after release.
- Update rule per rising edge, first matching condition wins:
  1. flush_in=1: load bubble (all fields at reset values). Flush beats every stall combination.
  2. stall_id_in=1 and stall_exe_in=0: load bubble. Decode is held, so its instruction must not issue twice.
  3. stall_exe_in=1: hold all registers unchanged.
  4. Otherwise: capture all inputs; valid_out=1.
- Captured instruction with inst_in[6:0] not one of the nine RV32I opcodes: valid_out=0, all other fields captured as-is.
- pre_inst_is_load_out is registered, not derived combinationally from outputs:
  - Set when the captured instruction has inst_in[6:0]=7'b0000011 and reg_we_in=1.
  - Cleared by bubble or reset; held during a hold.
- exe_rd_out mirrors reg_waddr_out. It is forced to 0 whenever reg_we_out=0, so decode never matches a stale rd.
- Latency: exactly one cycle from input to output.
- No combinational path from any input to any output.
- A load followed by a dependent instruction produces exactly one bubble: decode raises stall, ctrl asserts stall_id_in only, and the bubble clears pre_inst_is_load_out so decode releases on the next cycle.

Optional Feature:
- Macro: ID_EXE_PERF_CNT_EN.
- Defined: adds two 32-bit output counters.
  - bubble_cnt_out increments once per bubble inserted by rule 2.
  - flush_cnt_out increments once per cycle with flush_in=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
  - A flush cycle with stall_id_in=1 counts only as a flush.
- Not defined: both ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation:
  - Stimulus: capture inst_in=32'h00500093 (addi x1,x0,5), op1_in=5; pulse reset_n_in low between clock edges.
  - Required: outputs go to reset values immediately, without a clock edge.
- Normal capture:
  - Stimulus: inst_in=32'h002081B3 (add x3,x1,x2), op1_in=7, op2_in=9, reg_we_in=1, reg_waddr_in=3.
  - Required: next cycle outputs equal inputs, valid_out=1, exe_rd_out=3, pre_inst_is_load_out=0.
- Load-use bubble:
  - Stimulus: capture lw x5,0(x1) (32'h0000A283); next cycle stall_id_in=1, stall_exe_in=0.
  - Required: load cycle shows pre_inst_is_load_out=1, exe_rd_out=5; following cycle shows inst_out=NOP_INST, valid_out=0, pre_inst_is_load_out=0.
- Hold:
  - Stimulus: stall_id_in=1 and stall_exe_in=1 for 3 cycles with random inputs.
  - Required: outputs unchanged for all 3 cycles.
- Flush priority:
  - Stimulus: flush_in=1 together with stall_exe_in=1.
  - Required: bubble loaded (inst_out=32'h00000013, reg_we_out=0); with ID_EXE_PERF_CNT_EN, flush_cnt_out increments by 1 and bubble_cnt_out is unchanged.
- Invalid opcode:
  - Stimulus: inst_in=32'hFFFFFFFF.
  - Required: valid_out=0, reg_we_out as presented on input, pre_inst_is_load_out=0.
